// File: rtl/fir_block_serializer.sv
// Rounds and saturates each lane of an L-parallel FIR output block, buffers whole blocks, and emits them one sample per handshake.
// Optional feature macro: SERIALIZER_SAT_COUNT_EN adds the sat_count clip counter port.
module fir_block_serializer #(
    parameter int L            = 2,
    parameter int IN_WIDTH     = 40,
    parameter int SAMPLE_WIDTH = 16,
    parameter int SHIFT        = 15,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic signed [IN_WIDTH-1:0]     in_block [L-1:0],
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic signed [SAMPLE_WIDTH-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           overflow,
`ifdef SERIALIZER_SAT_COUNT_EN
    output logic [15:0]                    sat_count,
`endif
    input  logic                           clear_ovf
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LANE_W = $clog2(L);
    localparam int EXT_W  = IN_WIDTH + 1;

    localparam logic signed [EXT_W-1:0] ROUND_K = EXT_W'(1) << (SHIFT - 1);
    localparam logic signed [EXT_W-1:0] SAT_MAX =
        {{(IN_WIDTH - SAMPLE_WIDTH + 2){1'b0}}, {(SAMPLE_WIDTH - 1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN =
        {{(IN_WIDTH - SAMPLE_WIDTH + 2){1'b1}}, {(SAMPLE_WIDTH - 1){1'b0}}};

    logic signed [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH][L];
    logic signed [EXT_W-1:0]        rnd  [L];
    logic signed [SAMPLE_WIDTH-1:0] conv [L];
    logic [L-1:0]                   clip;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [LANE_W-1:0] lane_idx;

    logic push;
    logic drop;
    logic pop;
    logic pop_blk;
    logic last_lane;

    // Sign-extend by one bit first so adding the half-LSB constant can never wrap.
    always_comb begin
        for (int i = 0; i < L; i++) begin
            rnd[i]  = ($signed({in_block[i][IN_WIDTH-1], in_block[i]}) + ROUND_K) >>> SHIFT;
            clip[i] = 1'b0;
            conv[i] = rnd[i][SAMPLE_WIDTH-1:0];
            if (rnd[i] > SAT_MAX) begin
                conv[i] = SAT_MAX[SAMPLE_WIDTH-1:0];
                clip[i] = 1'b1;
            end else if (rnd[i] < SAT_MIN) begin
                conv[i] = SAT_MIN[SAMPLE_WIDTH-1:0];
                clip[i] = 1'b1;
            end
        end
    end

    assign in_ready  = (count != CNT_W'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign last_lane = (lane_idx == LANE_W'(L - 1));
    assign out_last  = out_valid & last_lane;
    assign out_data  = out_valid ? mem[rd_ptr][lane_idx] : '0;

    assign push    = in_valid & in_ready;
    assign drop    = in_valid & ~in_ready;
    assign pop     = out_valid & out_ready;
    assign pop_blk = pop & last_lane;

    // NOTE: the sample store has no reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < L; i++) begin
                mem[wr_ptr][i] <= conv[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            lane_idx <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_blk) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (pop) begin
                lane_idx <= last_lane ? '0 : lane_idx + LANE_W'(1);
            end
            case ({push, pop_blk})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear request keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef SERIALIZER_SAT_COUNT_EN
    logic [16:0] sat_sum;

    always_comb begin
        sat_sum = clear_ovf ? 17'd0 : {1'b0, sat_count};
        if (push) begin
            for (int i = 0; i < L; i++) begin
                sat_sum = sat_sum + 17'(clip[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else begin
            sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_fir_block_serializer.sv
// Randomized self-checking bench for fir_block_serializer against a sample-queue reference model.
`timescale 1ns/1ps
module tb_fir_block_serializer;
    localparam int L            = 2;
    localparam int IN_WIDTH     = 40;
    localparam int SAMPLE_WIDTH = 16;
    localparam int SHIFT        = 15;
    localparam int FIFO_DEPTH   = 2;

    logic                           clk = 1'b0;
    logic                           rst_n = 1'b0;
    logic signed [IN_WIDTH-1:0]     in_block [L-1:0];
    logic                           in_valid = 1'b0;
    logic                           in_ready;
    logic signed [SAMPLE_WIDTH-1:0] out_data;
    logic                           out_valid;
    logic                           out_ready = 1'b0;
    logic                           out_last;
    logic                           overflow;
    logic                           clear_ovf = 1'b0;
`ifdef SERIALIZER_SAT_COUNT_EN
    logic [15:0]                    sat_count;
`endif

    fir_block_serializer #(
        .L(L), .IN_WIDTH(IN_WIDTH), .SAMPLE_WIDTH(SAMPLE_WIDTH),
        .SHIFT(SHIFT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_block(in_block),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .overflow(overflow),
`ifdef SERIALIZER_SAT_COUNT_EN
        .sat_count(sat_count),
`endif
        .clear_ovf(clear_ovf)
    );

    always #5 clk = ~clk;

    // Reference model: flat queue of pending samples in emission order plus position within the head block.
    int smp_q[$];
    int pos   = 0;
    bit m_ovf = 1'b0;
    int m_sat = 0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic longint round_lane(input logic signed [IN_WIDTH-1:0] x);
        return (longint'(x) + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    endfunction

    function automatic longint sat_lane(input longint v);
        longint hi = (longint'(1) <<< (SAMPLE_WIDTH - 1)) - 1;
        longint lo = -(longint'(1) <<< (SAMPLE_WIDTH - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint rnd_lane();
        case ($urandom_range(0, 3))
            0:       return longint'({$urandom, $urandom});
            1:       return longint'(int'($urandom));
            2:       return (longint'($urandom_range(0, 4000)) - 2000) * 32768 + 16384
                            + longint'($urandom_range(0, 2)) - 1;
            default: return longint'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    task automatic model_clear();
        smp_q.delete();
        pos   = 0;
        m_ovf = 1'b0;
        m_sat = 0;
    endtask

    task automatic drive(input bit v, input longint a, input longint b, input bit ordy, input bit clr);
        in_valid    = v;
        in_block[0] = IN_WIDTH'(a);
        in_block[1] = IN_WIDTH'(b);
        for (int i = 2; i < L; i++) in_block[i] = '0;
        out_ready   = ordy;
        clear_ovf   = clr;
    endtask

    task automatic step();
        int occ;
        bit acc;
        bit popd;
        longint v;
        longint s;
        @(negedge clk);
        occ = (smp_q.size() + pos) / L;
        check("out_valid", 64'(out_valid), 64'(smp_q.size() != 0));
        check("out_data", 64'(out_data), (smp_q.size() != 0) ? 64'(smp_q[0]) : 64'sd0);
        check("out_last", 64'(out_last), 64'((smp_q.size() != 0) && (pos == L - 1)));
        check("in_ready", 64'(in_ready), 64'(occ < FIFO_DEPTH));
        check("overflow", 64'(overflow), 64'(m_ovf));
`ifdef SERIALIZER_SAT_COUNT_EN
        check("sat_count", 64'(sat_count), 64'(m_sat));
`endif
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            acc  = in_valid && (occ < FIFO_DEPTH);
            popd = (smp_q.size() != 0) && out_ready;
            if (popd) begin
                void'(smp_q.pop_front());
                pos = (pos + 1) % L;
            end
            if (clear_ovf) m_sat = 0;
            if (acc) begin
                for (int i = 0; i < L; i++) begin
                    v = round_lane(in_block[i]);
                    s = sat_lane(v);
                    if (s != v) m_sat++;
                    smp_q.push_back(int'(s));
                end
            end
            if (m_sat > 65535) m_sat = 65535;
            if (in_valid && !acc) m_ovf = 1'b1;
            else if (clear_ovf)   m_ovf = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 0, 0, ordy, 1'b0);
            step();
        end
    endtask

    initial begin
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        idle(1, 1'b1);

        // Rounding at exact halves and just below
        drive(1'b1, 32768, 16384, 1'b1, 1'b0);   step();
        idle(3, 1'b1);
        drive(1'b1, -16384, -16385, 1'b1, 1'b0); step();
        idle(3, 1'b1);

        // Saturation both ways
        drive(1'b1, 64'sd1 <<< 31, -(64'sd1 <<< 31), 1'b1, 1'b0); step();
        idle(3, 1'b1);

        // Back-to-back blocks with toggling backpressure
        drive(1'b1, 1 << 15, 2 << 15, 1'b1, 1'b0); step();
        drive(1'b1, 3 << 15, 4 << 15, 1'b0, 1'b0); step();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 0, 0, (i % 2) == 0, 1'b0);
            step();
        end

        // Fill, drop a third block, drain, then clear the sticky flag
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, (20 + 2 * i) << 15, (21 + 2 * i) << 15, 1'b0, 1'b0);
            step();
        end
        idle(6, 1'b1);
        drive(1'b0, 0, 0, 1'b1, 1'b1); step();
        idle(1, 1'b1);

        // Full FIFO while the final lane pops: push refused, accepted next cycle
        drive(1'b1, 30 << 15, 31 << 15, 1'b0, 1'b0); step();
        drive(1'b1, 32 << 15, 33 << 15, 1'b0, 1'b0); step();
        idle(1, 1'b1);
        drive(1'b1, 7 << 15, 8 << 15, 1'b1, 1'b0);   step();
        drive(1'b1, 9 << 15, 10 << 15, 1'b1, 1'b0);  step();
        idle(8, 1'b1);
        drive(1'b0, 0, 0, 1'b1, 1'b1); step();

        // Asynchronous reset after lane 0 of a block was consumed
        drive(1'b1, 11 << 15, 12 << 15, 1'b1, 1'b0); step();
        idle(1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check("rst_out_valid", 64'(out_valid), 64'sd0);
        check("rst_out_data", 64'(out_data), 64'sd0);
        check("rst_out_last", 64'(out_last), 64'sd0);
        check("rst_in_ready", 64'(in_ready), 64'sd1);
        check("rst_overflow", 64'(overflow), 64'sd0);
        idle(1, 1'b1);
        rst_n = 1'b1;
        drive(1'b1, 5 << 15, 6 << 15, 1'b1, 1'b0); step();
        idle(3, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1) == 1, rnd_lane(), rnd_lane(),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
            step();
        end
        idle(2 * FIFO_DEPTH * L + 2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fir_block_serializer.md
Name:
fir_block_serializer

Overview:
- Downstream stage of the L-parallel FIR filter. Accepts one block of L wide filter outputs per handshake.
- Rounds and saturates each lane to the system sample width, buffers up to FIFO_DEPTH blocks, and emits samples one per handshake in time order: lane 0 (y(Lk)) first, lane L-1 (y(Lk+L-1)) last.
- Bridges the filter's block-rate output to the single-sample stream consumed by the DAC/capture logic.

Parameters:
- L, 2, lanes per block; must match the filter; legal values 2 or 3.
- IN_WIDTH, 40, width of each filter output lane (signed).
- SAMPLE_WIDTH, 16, width of each emitted sample (signed).
- SHIFT, 15, number of LSBs discarded during rounding; legal range 1..IN_WIDTH-SAMPLE_WIDTH.
- FIFO_DEPTH, 2, block entries buffered; must be a power of two and at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_block  in  L x IN_WIDTH  unpacked signed array y[L-1:0] from the filter.
- in_valid  in  1  in_block holds a new block.
- in_ready  out  1  FIFO can accept a block.
- out_data  out  SAMPLE_WIDTH  current signed sample.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- out_last  out  1  out_data is lane L-1 of its block.
- overflow  out  1  sticky: a block was offered while the FIFO was full.
- clear_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset (asynchronous, rst_n=0): FIFO empty, read/write pointers 0, lane index 0, overflow 0, out_valid 0, in_ready 1, out_last 0, out_data 0.
- Push: on in_valid & in_ready, every lane is converted and the SAMPLE_WIDTH results are written into the FIFO tail.
- Conversion per lane:
  - Compute v = (lane + 2^(SHIFT-1)) >>> SHIFT, with arithmetic shift, evaluated at IN_WIDTH+1 bits so the rounding constant cannot wrap.
  - This is round-half-up, i.e. toward +inf on exact halves.
  - Saturate v to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
- in_ready = (count < FIFO_DEPTH), using the registered count only. It does not depend combinationally on out_ready.
- Drop: in_valid & !in_ready discards the block, sets overflow, and leaves FIFO contents and pointers unchanged.
- Output:
  - out_valid = (count != 0).
  - out_data = head entry, lane[lane_idx].
  - out_last = out_valid & (lane_idx == L-1).
  - All three are driven from registers and stored data, with no combinational path from in_block.
- Pop:
  - On out_valid & out_ready, lane_idx increments.
  - If lane_idx == L-1, lane_idx wraps to 0, the head entry is freed, and the read pointer advances modulo FIFO_DEPTH.
- Latency: a block accepted in cycle t presents lane 0 with out_valid=1 in cycle t+1 if the FIFO was empty.
- Throughput: one sample per cycle while out_ready=1. The sustained input rate is therefore one block per L cycles.
- Simultaneous push and final-lane pop in the same cycle: count is unchanged and both pointers advance.
  - When full, the push is still refused that cycle, because in_ready is registered.
  - in_ready rises the following cycle.
- A push into an empty FIFO never causes out_valid in the same cycle.
- out_valid is held with out_data stable until accepted; the consumer may stall indefinitely.
- Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- clear_ovf=1 clears overflow next cycle. If a drop occurs in the same cycle, the set wins.
- Reset asserted mid-block discards all buffered data and the partial-block position. The first sample after release is lane 0 of the next pushed block.

Optional Feature:
- Macro SERIALIZER_SAT_COUNT_EN.
- When defined:
  - Adds output port sat_count [15:0], reset to 0.
  - sat_count increments once per lane whose value was clipped during an accepted push. Clips in all lanes of one block are summed, adding up to L per cycle.
  - sat_count saturates at 16'hFFFF and is cleared by clear_ovf.
- When undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Rounding: L=2, SHIFT=15, push lanes {32768, 16384} -> out_data 1 (lane 0), then 1 with out_last=1; push {-16384, -16385} -> 0, then -1.
- Saturation: push {2^31, -2^31} -> 32767, then -32768; with SERIALIZER_SAT_COUNT_EN, sat_count=2.
- Ordering and backpressure: push two blocks {1<<15, 2<<15} and {3<<15, 4<<15} back-to-back, out_ready toggling 1,0,1,0 -> outputs 1,2,3,4 in order, data held stable while stalled, out_last on 2 and 4.
- Full/drop: out_ready=0, push 3 blocks -> first two accepted, in_ready=0 on the third, overflow=1; drain -> only the first two blocks appear; clear_ovf -> overflow=0 next cycle.
- Full with simultaneous pop: FIFO full and lane 1 popping while in_valid=1 -> push refused that cycle, in_ready=1 next cycle, next push accepted, no data lost or duplicated.
- Reset mid-block: after lane 0 of a block is consumed, pulse rst_n=0 asynchronously -> outputs return to reset values immediately; after release, push {5<<15, 6<<15} -> outputs 5 then 6.
